multdiv_ctrl: RTL and testbench

Sequencing controller between the execute stage and the `multdiv` unit. It accepts one multiply or divide request at a time and drives a single-cycle `ctrl_MULT`/`ctrl_DIV` start pulse with stable operands. It stalls the pipeline while the operation runs, then holds the result, exception flag and destination register until writeback acknowledges them. An optional watchdog aborts operations whose `resultRDY` never arrives.

---
 rtl/multdiv_ctrl.sv | 142 ++++++++++++++
 tb/tb_multdiv_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// Sequencing controller between execute and the multdiv unit: one operation in flight,
// start pulse, pipeline stall, result hold until writeback. Watchdog built with MULTDIV_TIMEOUT_EN.
module multdiv_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_mult,
    input  logic        req_div,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception,
    output logic [2:0]  wb_status,
    input  logic        wb_ack
);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        finish;
    logic        timeout_hit;
    logic        op_mult;
    logic [4:0]  rd_q;

    function automatic logic [2:0] exc_status(input logic is_mult, input logic exc);
        if (!exc)
            return 3'd0;
        return is_mult ? 3'd4 : 3'd5;
    endfunction

    assign accept = (state == IDLE) && (req_mult || req_div) && !flush;
    assign finish = (state == BUSY) && (md_resultRDY || timeout_hit) && !flush;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] busy_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            busy_cnt <= '0;
        else if (state == BUSY && state_nxt == BUSY)
            busy_cnt <= busy_cnt + CNT_W'(1);
        else
            busy_cnt <= '0;
    end

    // Fires on the TIMEOUT_CYCLES-th BUSY cycle; a resultRDY in that same cycle still wins.
    assign timeout_hit = (state == BUSY) && !md_resultRDY
                         && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: BUSY waits for md_resultRDY indefinitely.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (req_mult || req_div) state_nxt = START;
                START: state_nxt = BUSY;
                BUSY:  if (md_resultRDY || timeout_hit) state_nxt = DONE;
                DONE:  if (wb_ack) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
        case (state)
            START, BUSY: stall = 1'b1;
            DONE:        stall = !wb_ack;
            default:     stall = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_operandA  <= '0;
            md_operandB  <= '0;
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            op_mult      <= 1'b0;
            rd_q         <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_exception <= 1'b0;
            wb_status    <= '0;
        end else begin
            // Start pulses are high only in the START cycle that follows acceptance.
            md_ctrl_MULT <= accept && req_mult;
            md_ctrl_DIV  <= accept && !req_mult;
            if (accept) begin
                md_operandA <= req_a;
                md_operandB <= req_b;
                op_mult     <= req_mult;
                rd_q        <= req_rd;
            end
            if (flush) begin
                wb_valid <= 1'b0;
            end else if (finish) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                if (md_resultRDY) begin
                    wb_data      <= md_result;
                    wb_exception <= md_exception;
                    wb_status    <= exc_status(op_mult, md_exception);
                end else begin
                    wb_data      <= '0;
                    wb_exception <= 1'b1;
                    wb_status    <= 3'd7;
                end
            end else if (state == DONE && wb_ack) begin
                wb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: a stub multdiv, a transaction-level model checked every
// cycle, and literal expectations for the documented scenarios.
module tb_multdiv_ctrl;

    localparam int TO = 8;
`ifdef MULTDIV_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_mult = 1'b0;
    logic        req_div = 1'b0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [4:0]  req_rd = '0;
    logic        flush = 1'b0;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_resultRDY = 1'b0;
    logic        wb_ack = 1'b0;

    logic        stall;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic [2:0]  wb_status;

    int checks = 0;
    int errors = 0;

    multdiv_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .req_mult(req_mult), .req_div(req_div), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .flush(flush), .stall(stall),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_exception(wb_exception), .wb_status(wb_status), .wb_ack(wb_ack)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: age = cycles since the accepting edge (0 = nothing in flight); held = result waiting.
    int          age = 0;
    bit          m_held = 1'b0;
    bit          m_mult = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [4:0]  m_rd = '0;
    logic [4:0]  m_wrd = '0;
    logic [31:0] m_data = '0;
    bit          m_exc = 1'b0;
    logic [2:0]  m_status = '0;

    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            age = 0; m_held = 1'b0; m_a = '0; m_b = '0;
        end else if (flush) begin
            age = 0; m_held = 1'b0;
        end else if (m_held) begin
            if (wb_ack) m_held = 1'b0;
        end else if (age == 0) begin
            if (req_mult || req_div) begin
                age = 1; m_mult = req_mult; m_a = req_a; m_b = req_b; m_rd = req_rd;
            end
        end else if (age >= 2 && md_resultRDY) begin
            age = 0; m_held = 1'b1; m_wrd = m_rd; m_data = md_result; m_exc = md_exception;
            m_status = !md_exception ? 3'd0 : (m_mult ? 3'd4 : 3'd5);
        end else if (TO_EN && (age - 1) >= TO) begin
            age = 0; m_held = 1'b1; m_wrd = m_rd; m_data = '0; m_exc = 1'b1; m_status = 3'd7;
        end else begin
            age++;
        end
    end

    initial forever begin
        @(negedge clock);
        chk("cyc_stall", stall, (age > 0 && !m_held) || (m_held && !wb_ack));
        chk("cyc_ctrl_mult", md_ctrl_MULT, age == 1 && m_mult);
        chk("cyc_ctrl_div", md_ctrl_DIV, age == 1 && !m_mult);
        chk("cyc_opa", md_operandA, m_a);
        chk("cyc_opb", md_operandB, m_b);
        chk("cyc_valid", wb_valid, m_held);
        if (m_held) begin
            chk("cyc_wb_rd", wb_rd, m_wrd);
            chk("cyc_wb_data", wb_data, m_data);
            chk("cyc_wb_exc", wb_exception, m_exc);
            chk("cyc_wb_status", wb_status, m_status);
        end
    end

    // Stub multdiv: RDY pulses stub_delay cycles after the START cycle (never if negative).
    int stub_delay = 4;
    int stub_cnt = -1;
    bit stub_exc = 1'b0;

    task automatic step();
        @(posedge clock);
        #1;
        md_resultRDY = 1'b0;
        if (md_ctrl_MULT || md_ctrl_DIV) begin
            stub_cnt = 0;
            md_exception = stub_exc;
            if (md_ctrl_MULT)
                md_result = md_operandA * md_operandB;
            else
                md_result = (md_operandB != 0) ? md_operandA / md_operandB : 32'd0;
        end else if (stub_cnt >= 0) begin
            stub_cnt++;
            if (stub_cnt == stub_delay) begin
                md_resultRDY = 1'b1;
                stub_cnt = -1;
            end
        end
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        req_mult = m; req_div = d; req_a = a; req_b = b; req_rd = rd;
        step();
        req_mult = 1'b0; req_div = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!wb_valid && n < budget) begin
            step();
            n++;
        end
        chk({name, "_valid_in_time"}, wb_valid, 1);
    endtask

    task automatic ack();
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_ctrl_mult", md_ctrl_MULT, 0);
        chk("rst_ctrl_div", md_ctrl_DIV, 0);
        chk("rst_opa", md_operandA, 0);
        chk("rst_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_status", wb_status, 0);
        reset = 1'b1;
        step();

        // Plain multiply, RDY four cycles after START.
        stub_delay = 4; stub_exc = 1'b0;
        issue(1, 0, 6, 7, 3);
        chk("t1_pulse_mult", md_ctrl_MULT, 1);
        chk("t1_no_div", md_ctrl_DIV, 0);
        step();
        chk("t1_pulse_once", md_ctrl_MULT, 0);
        wait_valid("t1", 10);
        chk("t1_data", wb_data, 42);
        chk("t1_rd", wb_rd, 3);
        chk("t1_status", wb_status, 0);
        chk("t1_model_data", m_data, 42);
        wb_ack = 1'b1;
        #1;
        chk("t1_ack_stall", stall, 0);
        step();
        wb_ack = 1'b0;
        chk("t1_idle_stall", stall, 0);
        chk("t1_idle_valid", wb_valid, 0);

        // Divide with exception at minimum latency.
        stub_delay = 1; stub_exc = 1'b1;
        issue(0, 1, 100, 7, 9);
        chk("t2_pulse_div", md_ctrl_DIV, 1);
        step();
        chk("t2_busy_no_valid", wb_valid, 0);
        step();
        chk("t2_min_latency", wb_valid, 1);
        chk("t2_exc", wb_exception, 1);
        chk("t2_status", wb_status, 5);
        chk("t2_data", wb_data, 14);
        chk("t2_model_status", m_status, 5);
        ack();

        // Multiply exception.
        stub_delay = 3;
        issue(1, 0, 3, 4, 1);
        wait_valid("t2m", 10);
        chk("t2m_status", wb_status, 4);
        chk("t2m_data", wb_data, 12);
        ack();
        stub_exc = 1'b0;

        // Both requests: multiply wins; stale RDY in START is ignored.
        stub_delay = 4;
        issue(1, 1, 3, 5, 2);
        md_resultRDY = 1'b1;
        chk("t3_mult_wins", md_ctrl_MULT, 1);
        chk("t3_div_dropped", md_ctrl_DIV, 0);
        step();
        chk("t3_busy_stall", stall, 1);
        chk("t3_stale_ignored", wb_valid, 0);
        wait_valid("t3", 10);
        chk("t3_data", wb_data, 15);
        ack();

        // Flush in BUSY, then a late RDY must not produce a result.
        issue(1, 0, 2, 2, 6);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_flush_stall", stall, 0);
        chk("t4_flush_valid", wb_valid, 0);
        repeat (6) step();
        chk("t4_late_rdy_valid", wb_valid, 0);
        chk("t4_late_rdy_stall", stall, 0);
        flush = 1'b1; req_mult = 1'b1; req_a = 77;
        step();
        flush = 1'b0; req_mult = 1'b0;
        chk("t4_flush_beats_req", md_ctrl_MULT, 0);
        chk("t4_opa_kept", md_operandA, 2);

        // Writeback back-pressure, then back-to-back request.
        stub_delay = 2;
        issue(1, 0, 9, 9, 17);
        wait_valid("t5", 10);
        repeat (5) begin
            step();
            chk("t5_hold_data", wb_data, 81);
            chk("t5_hold_rd", wb_rd, 17);
            chk("t5_hold_stall", stall, 1);
        end
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        req_div = 1'b1; req_a = 50; req_b = 5; req_rd = 4;
        step();
        req_div = 1'b0;
        chk("t5_b2b_div", md_ctrl_DIV, 1);
        chk("t5_b2b_opa", md_operandA, 50);
        wait_valid("t5b", 10);
        chk("t5b_data", wb_data, 10);
        chk("t5b_rd", wb_rd, 4);
        ack();

        // Multdiv that never answers.
        stub_delay = -1;
        issue(1, 0, 1, 1, 8);
`ifdef MULTDIV_TIMEOUT_EN
        wait_valid("t6_timeout", TO + 5);
        chk("t6_status", wb_status, 7);
        chk("t6_data", wb_data, 0);
        chk("t6_exc", wb_exception, 1);
        chk("t6_rd", wb_rd, 8);
        ack();
        issue(0, 1, 4, 2, 8);
        repeat (3) step();
`else
        repeat (100) step();
        chk("t6_still_busy", stall, 1);
        chk("t6_no_valid", wb_valid, 0);
`endif

        // Asynchronous reset in the middle of BUSY.
        #1;
        reset = 1'b0;
        #1;
        chk("t7_rst_stall", stall, 0);
        chk("t7_rst_ctrl", md_ctrl_MULT | md_ctrl_DIV, 0);
        chk("t7_rst_opa", md_operandA, 0);
        chk("t7_rst_valid", wb_valid, 0);
        step();
        reset = 1'b1;

        // Recovery after reset.
        stub_delay = 2;
        issue(0, 1, 21, 3, 5);
        wait_valid("t8", 10);
        chk("t8_data", wb_data, 7);
        chk("t8_rd", wb_rd, 5);
        ack();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
